// File: rtl/task_rle_pkg.sv
// rtl/task_rle_pkg.sv - shared types and constants for the RLE task encoder
package task_rle_pkg;

    typedef enum logic [1:0] {
        RECV     = 2'd0,
        FLUSH    = 2'd1,
        ANNOUNCE = 2'd2,
        SEND     = 2'd3
    } rle_state_t;

    localparam logic [7:0] RLE_MAX_RUN = 8'd255;

    typedef struct packed {
        logic [7:0] count;
        logic [7:0] value;
    } rle_pair_t;

endpackage

// File: rtl/task_rle_pair_buf.sv
// rtl/task_rle_pair_buf.sv - simple dual-port pair store with registered read
module task_rle_pair_buf
    import task_rle_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  rle_pair_t     wdata,
    input  logic [AW-1:0] raddr,
    output rle_pair_t     rdata
);

    rle_pair_t mem [DEPTH];

    // One write port and a one-cycle registered read port; contents need no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/task_rle_encoder.sv
// rtl/task_rle_encoder.sv - store-and-forward run-length encoder on a task slot
module task_rle_encoder
    import task_rle_pkg::*;
#(
    parameter int TASK_DATA_WIDTH   = 8,
    parameter int PACKET_SIZE_WIDTH = 12,
    parameter int MAX_IN_BYTES      = 1024
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_tdata_valid,
    input  logic [TASK_DATA_WIDTH-1:0]   i_tdata,
    input  logic                         i_tdata_last,
    output logic                         o_tready,
    output logic                         o_tanswer_ready,
    input  logic                         i_tmanager_ready,
    output logic [TASK_DATA_WIDTH-1:0]   o_tanswer_data,
    output logic                         o_tanswer_data_last,
    output logic [PACKET_SIZE_WIDTH-1:0] o_packet_size_in_bytes
);

    localparam int AW = $clog2(MAX_IN_BYTES);
    localparam int CW = AW + 1;

    rle_state_t                   state;
    rle_state_t                   next_state;
    logic                         tready_q;
    logic [7:0]                   run_val;
    logic [7:0]                   run_cnt;
    logic [CW-1:0]                in_cnt;
    logic [CW-1:0]                pair_count;
    logic [AW-1:0]                rd_ptr;
    logic [AW-1:0]                rd_addr;
    rle_pair_t                    rd_pair;
    rle_pair_t                    cur_pair;
    logic                         byte_sel;
    logic [PACKET_SIZE_WIDTH-1:0] size_q;
    logic                         wr_en;
    rle_pair_t                    wr_pair;
    logic                         accept;
    logic                         encode;
    logic                         run_continue;
    logic                         last_pair;

    assign accept       = i_tdata_valid & tready_q;
    // Bytes past the buffer capacity are handshaken but dropped from the encoding.
    assign encode       = accept & (in_cnt < CW'(MAX_IN_BYTES));
    assign run_continue = (in_cnt != '0) && (i_tdata == run_val) && (run_cnt != RLE_MAX_RUN);
    assign last_pair    = ({1'b0, rd_ptr} == (pair_count - CW'(1)));
    // The pair after the one being serialized is always being fetched, so the RAM output acts as the prefetch register.
    assign rd_addr      = rd_ptr + AW'(1);

    task_rle_pair_buf #(
        .DEPTH (MAX_IN_BYTES),
        .AW    (AW)
    ) u_pair_buf (
        .clk   (i_clk),
        .we    (wr_en),
        .waddr (pair_count[AW-1:0]),
        .wdata (wr_pair),
        .raddr (rd_addr),
        .rdata (rd_pair)
    );

    // Closed runs are written when a different byte or a full run arrives, and the pending run in FLUSH.
    always_comb begin
        wr_en   = 1'b0;
        wr_pair = '{count: run_cnt, value: run_val};
        if (state == RECV && encode && in_cnt != '0 && !run_continue) begin
            wr_en = 1'b1;
        end
        if (state == FLUSH) begin
            wr_en = 1'b1;
        end
    end

    // State register; o_tready is registered so it stays low through reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= RECV;
            tready_q <= 1'b0;
        end else begin
            state    <= next_state;
            tready_q <= (next_state == RECV);
        end
    end

    // Next-state decode for receive, flush, announce and send phases.
    always_comb begin
        next_state = state;
        case (state)
            RECV:     if (accept && i_tdata_last) next_state = FLUSH;
            FLUSH:    next_state = ANNOUNCE;
            ANNOUNCE: if (i_tmanager_ready) next_state = SEND;
            SEND:     if (i_tmanager_ready && byte_sel && last_pair) next_state = RECV;
            default:  next_state = RECV;
        endcase
    end

    // Run tracker, pair counting and output serializer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            run_val    <= '0;
            run_cnt    <= '0;
            in_cnt     <= '0;
            pair_count <= '0;
            rd_ptr     <= '0;
            cur_pair   <= '0;
            byte_sel   <= 1'b0;
            size_q     <= '0;
        end else begin
            case (state)
                RECV: begin
                    if (encode) begin
                        in_cnt <= in_cnt + CW'(1);
                        if (run_continue) begin
                            run_cnt <= run_cnt + 8'd1;
                        end else begin
                            run_val <= i_tdata;
                            run_cnt <= 8'd1;
                        end
                    end
                    if (wr_en) begin
                        pair_count <= pair_count + CW'(1);
                        // Pair 0 is captured directly so the first answer byte needs no RAM read.
                        if (pair_count == '0) cur_pair <= wr_pair;
                    end
                end
                FLUSH: begin
                    pair_count <= pair_count + CW'(1);
                    if (pair_count == '0) cur_pair <= wr_pair;
                    size_q   <= PACKET_SIZE_WIDTH'({pair_count + CW'(1), 1'b0});
                    rd_ptr   <= '0;
                    byte_sel <= 1'b0;
                end
                ANNOUNCE: begin
                    if (i_tmanager_ready) byte_sel <= 1'b1;
                end
                SEND: begin
                    if (i_tmanager_ready) begin
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
                        end else if (last_pair) begin
                            byte_sel   <= 1'b0;
                            rd_ptr     <= '0;
                            pair_count <= '0;
                            in_cnt     <= '0;
                        end else begin
                            cur_pair <= rd_pair;
                            rd_ptr   <= rd_ptr + AW'(1);
                            byte_sel <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tready               = tready_q;
    assign o_tanswer_ready        = (state == ANNOUNCE) || (state == SEND);
    assign o_tanswer_data         = !o_tanswer_ready ? '0 :
                                    (byte_sel ? cur_pair.value : cur_pair.count);
    assign o_tanswer_data_last    = (state == SEND) && byte_sel && last_pair;
    assign o_packet_size_in_bytes = size_q;

endmodule
